// File: rtl/xaui_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xaui_link_pkg
// Brief    : Shared constants, state encodings and comma detect for XAUI RX.
// Revision : 1.0
// ============================================================================
package xaui_link_pkg;

  localparam int unsigned NUM_LANES      = 4;
  localparam int unsigned BYTES_PER_LANE = 2;
  localparam int unsigned LANE_W         = 8 * BYTES_PER_LANE;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef logic [2:0] port_state_t;
  localparam port_state_t PORT_RST       = 3'd0;
  localparam port_state_t PORT_WAIT_LOCK = 3'd1;
  localparam port_state_t PORT_ALIGN     = 3'd2;
  localparam port_state_t PORT_DESKEW    = 3'd3;
  localparam port_state_t PORT_UP        = 3'd4;

  typedef logic [0:0] lane_state_t;
  localparam lane_state_t LANE_LOSS = 1'b0;
  localparam lane_state_t LANE_SYNC = 1'b1;

  // A lane carries a comma when any byte is a cleanly decoded K28.5.
  function automatic logic lane_has_comma(
    input logic [LANE_W-1:0]         data,
    input logic [BYTES_PER_LANE-1:0] charisk,
    input logic [BYTES_PER_LANE-1:0] codevalid
  );
    logic hit;
    hit = 1'b0;
    for (int b = 0; b < BYTES_PER_LANE; b++) begin
      if (charisk[b] && codevalid[b] && (data[8*b +: 8] == K28_5)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xaui_rx_link_ctrl_lane_sync.sv
`default_nettype none
// ============================================================================
// Module   : xaui_lane_sync
// Brief    : Per-lane code-group sync state machine with bad/good hysteresis.
// Revision : 1.0
// ============================================================================
module xaui_lane_sync
  import xaui_link_pkg::*;
#(
  parameter int unsigned COMMAS_TO_SYNC = 4,
  parameter int unsigned BAD_TO_LOSE    = 4,
  parameter int unsigned GOOD_RUN       = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [LANE_W-1:0]         data,
  input  logic [BYTES_PER_LANE-1:0] charisk,
  input  logic [BYTES_PER_LANE-1:0] codevalid,
  output logic                      lane_sync
);

  localparam int CNT_W = 8;

  lane_state_t      r_state;
  lane_state_t      w_next_state;
  logic [CNT_W-1:0] r_comma_cnt;
  logic [CNT_W-1:0] r_bad_cnt;
  logic [CNT_W-1:0] r_good_cnt;
  logic [CNT_W-1:0] w_comma_cnt_nxt;
  logic [CNT_W-1:0] w_bad_cnt_nxt;
  logic [CNT_W-1:0] w_good_cnt_nxt;
  logic             w_comma;
  logic             w_bad;

  assign w_comma = lane_has_comma(data, charisk, codevalid);
  assign w_bad   = ~&codevalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LANE_LOSS;
      r_comma_cnt <= '0;
      r_bad_cnt   <= '0;
      r_good_cnt  <= '0;
    end else begin
      r_state     <= w_next_state;
      r_comma_cnt <= w_comma_cnt_nxt;
      r_bad_cnt   <= w_bad_cnt_nxt;
      r_good_cnt  <= w_good_cnt_nxt;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_comma_cnt_nxt = r_comma_cnt;
    w_bad_cnt_nxt   = r_bad_cnt;
    w_good_cnt_nxt  = r_good_cnt;
    if (clear) begin
      w_next_state    = LANE_LOSS;
      w_comma_cnt_nxt = '0;
      w_bad_cnt_nxt   = '0;
      w_good_cnt_nxt  = '0;
    end else begin
      case (r_state)
        LANE_LOSS: begin
          w_bad_cnt_nxt  = '0;
          w_good_cnt_nxt = '0;
          // A corrupted cycle wins over a comma in the other byte.
          if (w_bad) begin
            w_comma_cnt_nxt = '0;
          end else if (w_comma) begin
            if (r_comma_cnt == CNT_W'(COMMAS_TO_SYNC - 1)) begin
              w_next_state    = LANE_SYNC;
              w_comma_cnt_nxt = '0;
            end else begin
              w_comma_cnt_nxt = r_comma_cnt + 1'b1;
            end
          end
        end
        LANE_SYNC: begin
          w_comma_cnt_nxt = '0;
          if (w_bad) begin
            w_good_cnt_nxt = '0;
            if (r_bad_cnt == CNT_W'(BAD_TO_LOSE - 1)) begin
              w_next_state  = LANE_LOSS;
              w_bad_cnt_nxt = '0;
            end else begin
              w_bad_cnt_nxt = r_bad_cnt + 1'b1;
            end
          end else if (r_good_cnt == CNT_W'(GOOD_RUN - 1)) begin
            w_good_cnt_nxt = '0;
            if (r_bad_cnt != '0) begin
              w_bad_cnt_nxt = r_bad_cnt - 1'b1;
            end
          end else begin
            w_good_cnt_nxt = r_good_cnt + 1'b1;
          end
        end
        default: begin
          w_next_state    = LANE_LOSS;
          w_comma_cnt_nxt = '0;
          w_bad_cnt_nxt   = '0;
          w_good_cnt_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    lane_sync = (r_state == LANE_SYNC);
  end

endmodule
`default_nettype wire

// File: rtl/xaui_rx_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : xaui_rx_link_ctrl
// Brief    : XAUI receive port bring-up: MGT reset, lane align, deskew, link.
// Revision : 1.0
// ============================================================================
module xaui_rx_link_ctrl
  import xaui_link_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = 64,
  parameter int unsigned LOCK_TIMEOUT   = 65535,
  parameter int unsigned DESKEW_TIMEOUT = 1023,
  parameter int unsigned COMMAS_TO_SYNC = 4,
  parameter int unsigned BAD_TO_LOSE    = 4,
  parameter int unsigned GOOD_RUN       = 4
) (
  input  logic                                mgt_clk,
  input  logic                                reset_n,
  input  logic [NUM_LANES*LANE_W-1:0]         mgt_rxdata,
  input  logic [NUM_LANES*BYTES_PER_LANE-1:0] mgt_rxcharisk,
  input  logic [NUM_LANES*BYTES_PER_LANE-1:0] mgt_codevalid,
  input  logic [NUM_LANES-1:0]                mgt_rxlock,
  input  logic [NUM_LANES-1:0]                mgt_syncok,
  input  logic [NUM_LANES-1:0]                mgt_rxbufferr,
  output logic [NUM_LANES-1:0]                mgt_rx_reset,
  output logic [NUM_LANES-1:0]                mgt_enable_align,
  output logic                                mgt_enchansync,
  output logic                                link_up,
  output logic [NUM_LANES-1:0]                lane_sync,
  output logic [15:0]                         reinit_count,
  output logic [15:0]                         bufferr_count
);

  localparam int TMR_W = 16;

  port_state_t          r_state;
  port_state_t          w_next_state;
  logic [TMR_W-1:0]     r_tmr;
  logic                 r_link_up;
  logic [15:0]          r_reinit_count;
  logic [15:0]          r_bufferr_count;
  logic [NUM_LANES-1:0] w_lane_sync;
  logic                 w_lane_clear;
  logic                 w_all_lock;
  logic                 w_all_sync;
  logic                 w_all_bond;
  logic                 w_any_bufferr;
  logic                 w_reinit;

  assign w_lane_clear  = (r_state == PORT_RST);
  assign w_all_lock    = &mgt_rxlock;
  assign w_all_sync    = &w_lane_sync;
  assign w_all_bond    = &mgt_syncok;
  assign w_any_bufferr = |mgt_rxbufferr;
  assign w_reinit      = (w_next_state == PORT_RST) && (r_state != PORT_RST);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    xaui_lane_sync #(
      .COMMAS_TO_SYNC (COMMAS_TO_SYNC),
      .BAD_TO_LOSE    (BAD_TO_LOSE),
      .GOOD_RUN       (GOOD_RUN)
    ) u_lane_sync (
      .clk       (mgt_clk),
      .rst_n     (reset_n),
      .clear     (w_lane_clear),
      .data      (mgt_rxdata[LANE_W*i +: LANE_W]),
      .charisk   (mgt_rxcharisk[BYTES_PER_LANE*i +: BYTES_PER_LANE]),
      .codevalid (mgt_codevalid[BYTES_PER_LANE*i +: BYTES_PER_LANE]),
      .lane_sync (w_lane_sync[i])
    );
  end

  // Timer restarts on every state change and saturates in untimed states.
  always_ff @(posedge mgt_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= PORT_RST;
      r_tmr     <= '0;
      r_link_up <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_link_up <= (r_state == PORT_UP);
      if (w_next_state != r_state) begin
        r_tmr <= '0;
      end else if (r_tmr != '1) begin
        r_tmr <= r_tmr + 1'b1;
      end
    end
  end

  // Success conditions are tested before timeouts so they win a tie.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      PORT_RST: begin
        if (r_tmr == TMR_W'(RESET_CYCLES - 1)) w_next_state = PORT_WAIT_LOCK;
      end
      PORT_WAIT_LOCK: begin
        if (w_all_lock)                             w_next_state = PORT_ALIGN;
        else if (r_tmr == TMR_W'(LOCK_TIMEOUT - 1)) w_next_state = PORT_RST;
      end
      PORT_ALIGN: begin
        if (w_all_sync) w_next_state = PORT_DESKEW;
      end
      PORT_DESKEW: begin
        if (w_all_bond && w_all_sync)                 w_next_state = PORT_UP;
        else if (!w_all_sync)                         w_next_state = PORT_ALIGN;
        else if (r_tmr == TMR_W'(DESKEW_TIMEOUT - 1)) w_next_state = PORT_RST;
      end
      PORT_UP: begin
        if (!w_all_sync || w_any_bufferr || !w_all_lock) w_next_state = PORT_RST;
      end
      default: w_next_state = PORT_RST;
    endcase
  end

  always_comb begin
    mgt_rx_reset     = '0;
    mgt_enable_align = '0;
    mgt_enchansync   = 1'b0;
    case (r_state)
      PORT_RST:    mgt_rx_reset = '1;
      PORT_ALIGN:  mgt_enable_align = '1;
      PORT_DESKEW: begin
        mgt_enable_align = '1;
        mgt_enchansync   = 1'b1;
      end
      PORT_UP:     mgt_enchansync = 1'b1;
      default:     mgt_rx_reset = '0;
    endcase
  end

  always_ff @(posedge mgt_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reinit_count  <= '0;
      r_bufferr_count <= '0;
    end else begin
      if (w_reinit && (r_reinit_count != 16'hFFFF)) begin
        r_reinit_count <= r_reinit_count + 16'd1;
      end
      if (w_any_bufferr && (r_bufferr_count != 16'hFFFF)) begin
        r_bufferr_count <= r_bufferr_count + 16'd1;
      end
    end
  end

  assign link_up       = r_link_up;
  assign lane_sync     = w_lane_sync;
  assign reinit_count  = r_reinit_count;
  assign bufferr_count = r_bufferr_count;

endmodule
`default_nettype wire
